// File: rtl/isa_pkg.sv
// isa_pkg: opcode constants, instruction field positions and issue FSM states
package isa_pkg;
   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [2:0] OP_J_PFX = 3'b001;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_BLTZ  = 5'b01110;
   localparam logic [4:0] OP_BGEZ  = 5'b01111;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 11;
   localparam int EXT_MSB = 1;
   typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALTED} issue_state_t;
endpackage

// File: rtl/instr_issue_q2.sv
// instr_q2: two-entry {word, pc} FIFO; a push while full is taken only alongside a pop
module instr_q2 #(
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [15:0]     push_word,
   input  logic [PC_W-1:0] push_pc,
   input  logic            pop,
   input  logic            flush,
   output logic [15:0]     head_word,
   output logic [PC_W-1:0] head_pc,
   output logic            full,
   output logic            empty
);
   logic [15:0]     word_q [2];
   logic [15:0]     word_d [2];
   logic [PC_W-1:0] pc_q [2];
   logic [PC_W-1:0] pc_d [2];
   logic            rd_q, rd_d, wr_q, wr_d, do_push, do_pop;
   logic [1:0]      cnt_q, cnt_d;
   assign full      = cnt_q == 2'd2;
   assign empty     = cnt_q == 2'd0;
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_word = word_q[rd_q];
   assign head_pc   = pc_q[rd_q];
   always_comb begin
      word_d = word_q;
      pc_d   = pc_q;
      if (do_push) begin
         word_d[wr_q] = push_word;
         pc_d[wr_q]   = push_pc;
      end
      rd_d  = flush ? 1'b0 : rd_q ^ do_pop;
      wr_d  = flush ? 1'b0 : wr_q ^ do_push;
      cnt_d = flush ? 2'd0 : cnt_q + 2'(do_push) - 2'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '{default: '0};
         pc_q   <= '{default: '0};
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         word_q <= word_d;
         pc_q   <= pc_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/instr_issue.sv
// instr_issue: fetch/issue front end; owns the PC, fetches over req/ack and queues two
// words for decode. A redirect during an outstanding fetch lets it finish and drops its data.
module instr_issue
   import isa_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [15:0]     dec_instr,
   output logic [4:0]      dec_opcode,
   output logic [1:0]      dec_op_ext,
   output logic [PC_W-1:0] dec_pc,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            halted
);
   if (QDEPTH != 2) begin : g_bad_depth
      $error("instr_issue: QDEPTH must be 2");
   end
   issue_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, addr_q, addr_d, rpc;
   logic            drop_q, drop_d, full, empty, pop, push, ack_ok;
   assign rpc        = redirect_pc & ~PC_W'(1);
   assign pop        = dec_valid && dec_ready;
   assign ack_ok     = imem_ack && state_q == WAIT;
   assign push       = ack_ok && !drop_q && !redirect;
   assign imem_req   = !rst && (state_q == WAIT || (state_q == FETCH && !full && !redirect));
   assign imem_addr  = state_q == WAIT ? addr_q : pc_q;
   assign dec_valid  = !empty;
   assign dec_opcode = dec_instr[OPC_MSB:OPC_LSB];
   assign dec_op_ext = dec_instr[EXT_MSB:0];
   assign halted     = state_q == HALTED;
   instr_q2 #(.PC_W(PC_W)) u_q (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_word (imem_rdata),
      .push_pc   (addr_q),
      .pop       (pop),
      .flush     (redirect),
      .head_word (dec_instr),
      .head_pc   (dec_pc),
      .full      (full),
      .empty     (empty)
   );
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      drop_d  = drop_q;
      if (redirect) begin
         pc_d    = rpc;
         drop_d  = state_q == WAIT && !imem_ack;
         state_d = drop_d ? WAIT : FETCH;
      end else if (state_q == FETCH && !full) begin
         state_d = WAIT;
         addr_d  = pc_q;
      end else if (ack_ok) begin
         drop_d  = 1'b0;
         pc_d    = drop_q ? pc_q : addr_q + PC_W'(2);
         state_d = !drop_q && imem_rdata[OPC_MSB:OPC_LSB] == OP_HALT ? DRAIN : FETCH;
      end else if (state_q == DRAIN && pop && dec_opcode == OP_HALT) begin
         state_d = HALTED;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         drop_q  <= drop_d;
      end
   end
   a_ack_has_req: assert property (@(posedge clk) disable iff (rst) imem_ack |-> state_q == WAIT);
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: scoreboard bench; a responder acks fetches and queues expected issues,
// a monitor pops and compares them on every decode handshake.
module tb_instr_issue;
   typedef struct packed { logic [15:0] w; logic [15:0] pc; } ent_t;
   logic clk = 1'b0, rst = 1'b1;
   logic imem_req, imem_ack = 1'b0, dec_valid, dec_ready = 1'b0, redirect = 1'b0, halted;
   logic [15:0] imem_addr, imem_rdata = '0, dec_instr, dec_pc, redirect_pc = '0;
   logic [4:0] dec_opcode;
   logic [1:0] dec_op_ext;
   logic w_rst = 1'b1, w_req, w_ack = 1'b0, w_valid, w_ready = 1'b1, w_halted;
   logic [15:0] w_addr, w_rdata = '0, w_instr, w_pc;
   logic [4:0] w_opcode;
   logic [1:0] w_op_ext;
   logic [15:0] halt_addr = 16'hFFFF;
   logic [15:0] acked [$];
   ent_t sb [$];
   bit resp_en = 1'b0;
   int lat = 1, wcnt = 0, drop_req = 0, drop_done = 0;
   int n_chk = 0, n_fail = 0, n_issued = 0;
   always #5 clk = ~clk;
   instr_issue dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
      .dec_opcode(dec_opcode), .dec_op_ext(dec_op_ext), .dec_pc(dec_pc), .redirect(redirect),
      .redirect_pc(redirect_pc), .halted(halted)
   );
   instr_issue #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
      .imem_rdata(w_rdata), .dec_valid(w_valid), .dec_ready(w_ready), .dec_instr(w_instr),
      .dec_opcode(w_opcode), .dec_op_ext(w_op_ext), .dec_pc(w_pc), .redirect(1'b0),
      .redirect_pc(16'h0000), .halted(w_halted)
   );
   function automatic logic [15:0] word_for(input logic [15:0] a);
      return (a == halt_addr) ? 16'h0000 : {5'b11000, a[11:1] + 11'd1};
   endfunction
   // memory responder: acks a request after lat cycles of it being seen
   initial forever begin
      @(negedge clk);
      #1;
      imem_ack = 1'b0;
      if (rst || !resp_en || !imem_req) wcnt = 0;
      else if (wcnt >= lat) begin
         imem_ack   = 1'b1;
         imem_rdata = word_for(imem_addr);
         wcnt       = 0;
         acked.push_back(imem_addr);
         if (drop_done < drop_req) drop_done++;
         else sb.push_back({imem_rdata, imem_addr});
      end else wcnt++;
   end
   initial forever begin : monitor
      ent_t e;
      @(negedge clk);
      #3;
      if (!rst && dec_valid && dec_ready) begin
         n_issued++;
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got word %h pc %h, required no issue", dec_instr, dec_pc);
         end else begin
            e = sb.pop_front();
            if ({dec_instr, dec_pc, dec_opcode, dec_op_ext} !== {e.w, e.pc, e.w[15:11], e.w[1:0]}) begin
               n_fail++;
               $display("FAIL issue_order: got word %h pc %h opc %h ext %h, required word %h pc %h",
                        dec_instr, dec_pc, dec_opcode, dec_op_ext, e.w, e.pc);
            end
         end
      end
   end
   task automatic cyc();
      @(negedge clk);
      #2;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; resp_en = 1'b0; dec_ready = 1'b0; redirect = 1'b0; lat = 1; halt_addr = 16'hFFFF;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; resp_en = 1'b0;
      #2;
      n_chk++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", imem_req); end
      n_chk++;
      if ({dec_valid, halted} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: valid/halted got %b required 00", {dec_valid, halted}); end
      n_chk++;
      if ({dec_instr, dec_pc} !== 32'h0) begin n_fail++; $display("FAIL reset_dec: got %h required 0", {dec_instr, dec_pc}); end
      @(negedge clk);
      rst = 1'b0;
      #2;
      n_chk++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL reset_first_req: got %b/%h required 1/0000", imem_req, imem_addr); end
   endtask
   task automatic test_basic();
      int a0, i0;
      do_reset();
      a0 = acked.size(); i0 = n_issued;
      dec_ready = 1'b1; resp_en = 1'b1;
      for (int i = 0; i < 10 && !imem_ack; i++) cyc();
      n_chk++;
      if (imem_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack_timeout: got no ack, required one"); end
      cyc();
      n_chk++;
      if ({dec_valid, dec_pc} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL basic_latency: valid/pc got %b/%h required 1/0000", dec_valid, dec_pc); end
      for (int i = 0; i < 20 && acked.size() - a0 < 3; i++) cyc();
      resp_en = 1'b0;
      n_chk++;
      if (acked.size() - a0 != 3) begin n_fail++; $display("FAIL basic_acks: got %0d required 3", acked.size() - a0); end
      else begin
         n_chk++;
         if ({acked[a0], acked[a0+1], acked[a0+2]} !== {16'h0, 16'h2, 16'h4}) begin
            n_fail++; $display("FAIL basic_addr: got %h %h %h required 0000 0002 0004", acked[a0], acked[a0+1], acked[a0+2]);
         end
      end
      repeat (4) cyc();
      n_chk++;
      if (n_issued - i0 != 3 || sb.size() != 0) begin n_fail++; $display("FAIL basic_issued: got %0d left %0d required 3 left 0", n_issued - i0, sb.size()); end
   endtask
   task automatic test_backpressure();
      int a0, i0, rq;
      do_reset();
      a0 = acked.size(); i0 = n_issued; rq = 0;
      resp_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (i >= 6 && imem_req) rq++;
      end
      n_chk++;
      if (acked.size() - a0 != 2) begin n_fail++; $display("FAIL bp_queued: got %0d required 2", acked.size() - a0); end
      n_chk++;
      if (rq != 0) begin n_fail++; $display("FAIL bp_req_full: got %0d req cycles required 0", rq); end
      n_chk++;
      if (dec_valid !== 1'b1 || n_issued != i0) begin n_fail++; $display("FAIL bp_hold: valid %b issued %0d required 1/0", dec_valid, n_issued - i0); end
      dec_ready = 1'b1;
      repeat (12) cyc();
      resp_en = 1'b0;
      repeat (4) cyc();
      n_chk++;
      if (n_issued - i0 != acked.size() - a0 || acked.size() - a0 < 4 || sb.size() != 0) begin
         n_fail++; $display("FAIL bp_resume: issued %0d acked %0d left %0d required issued==acked>=4 left 0", n_issued - i0, acked.size() - a0, sb.size());
      end
   endtask
   task automatic test_halt();
      int a0, pop_c, halt_c, late;
      bit seen;
      do_reset();
      a0 = acked.size(); pop_c = -1; halt_c = -1; late = 0; seen = 1'b0;
      halt_addr = 16'h0006; dec_ready = 1'b1; resp_en = 1'b1;
      for (int c = 0; c < 30; c++) begin
         cyc();
         if (dec_valid && dec_ready && dec_instr == 16'h0000 && pop_c < 0) pop_c = c;
         if (halted && halt_c < 0) halt_c = c;
         if (seen && imem_req) late++;
         seen = acked.size() - a0 >= 4;
      end
      resp_en = 1'b0;
      n_chk++;
      if (acked.size() - a0 != 4 || acked[acked.size()-1] !== 16'h0006) begin n_fail++; $display("FAIL halt_acks: got %0d acks required 4 ending at 0006", acked.size() - a0); end
      n_chk++;
      if (late != 0) begin n_fail++; $display("FAIL halt_no_req: got %0d late req cycles required 0", late); end
      n_chk++;
      if (pop_c < 0 || halt_c != pop_c + 1) begin n_fail++; $display("FAIL halt_timing: pop %0d halted %0d required halted one cycle after pop", pop_c, halt_c); end
      n_chk++;
      if ({halted, dec_valid} !== 2'b10) begin n_fail++; $display("FAIL halt_final: halted/valid got %b required 10", {halted, dec_valid}); end
   endtask
   task automatic test_redirect_drop();
      int a0, i0;
      a0 = acked.size(); i0 = n_issued;
      halt_addr = 16'hFFFF; lat = 3; dec_ready = 1'b1; resp_en = 1'b1;
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h0009;
      @(negedge clk);
      redirect = 1'b0;
      #2;
      n_chk++;
      if ({halted, imem_req, imem_addr} !== {2'b01, 16'h0008}) begin n_fail++; $display("FAIL rd_fetch: halted/req/addr got %b/%b/%h required 0/1/0008", halted, imem_req, imem_addr); end
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h0020; drop_req++;
      #2;
      n_chk++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0008}) begin n_fail++; $display("FAIL rd_hold: req/addr got %b/%h required 1/0008", imem_req, imem_addr); end
      @(negedge clk);
      redirect_pc = 16'h0040;
      #2;
      n_chk++;
      if ({imem_req, imem_addr, dec_valid} !== {1'b1, 16'h0008, 1'b0}) begin n_fail++; $display("FAIL rd_second: req/addr/valid got %b/%h/%b required 1/0008/0", imem_req, imem_addr, dec_valid); end
      @(negedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 20 && acked.size() - a0 < 2; i++) cyc();
      resp_en = 1'b0;
      n_chk++;
      if (acked.size() - a0 != 2 || acked[a0] !== 16'h0008 || acked[a0+1] !== 16'h0040) begin
         n_fail++; $display("FAIL rd_addr: got %0d acks required 0008 then 0040", acked.size() - a0);
      end
      repeat (4) cyc();
      n_chk++;
      if (n_issued - i0 != 1 || sb.size() != 0) begin n_fail++; $display("FAIL rd_issued: got %0d left %0d required 1 left 0", n_issued - i0, sb.size()); end
   endtask
   task automatic test_wrap();
      @(negedge clk);
      w_rst = 1'b0;
      #2;
      n_chk++;
      if ({w_req, w_addr} !== {1'b1, 16'hFFFE}) begin n_fail++; $display("FAIL wrap_first: req/addr got %b/%h required 1/fffe", w_req, w_addr); end
      @(negedge clk);
      w_ack = 1'b1; w_rdata = 16'hC0FF;
      @(negedge clk);
      w_ack = 1'b0;
      #2;
      n_chk++;
      if ({w_req, w_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL wrap_second: req/addr got %b/%h required 1/0000", w_req, w_addr); end
      n_chk++;
      if ({w_valid, w_halted, w_instr, w_pc, w_opcode, w_op_ext} !== {2'b10, 16'hC0FF, 16'hFFFE, 5'b11000, 2'b11}) begin
         n_fail++; $display("FAIL wrap_issue: valid %b halted %b word %h pc %h required 1 0 c0ff fffe", w_valid, w_halted, w_instr, w_pc);
      end
      @(negedge clk);
      w_rst = 1'b1;
   endtask
   task automatic test_pop_push_redirect();
      int a0, i0;
      do_reset();
      a0 = acked.size(); i0 = n_issued;
      resp_en = 1'b1;
      for (int i = 0; i < 20 && acked.size() - a0 < 2; i++) cyc();
      repeat (2) cyc();
      n_chk++;
      if ({dec_valid, imem_req} !== 2'b10) begin n_fail++; $display("FAIL pp_full: valid/req got %b required 10", {dec_valid, imem_req}); end
      @(negedge clk);
      dec_ready = 1'b1;
      @(negedge clk);
      dec_ready = 1'b0;
      #2;
      for (int i = 0; i < 6 && !imem_ack; i++) cyc();
      n_chk++;
      if (imem_ack !== 1'b1) begin n_fail++; $display("FAIL pp_ack_timeout: got no ack, required one"); end
      dec_ready = 1'b1;
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h0100; resp_en = 1'b0;
      #2;
      n_chk++;
      if ({dec_valid, dec_pc} !== {1'b1, 16'h0004}) begin n_fail++; $display("FAIL pp_occupancy: valid/pc got %b/%h required 1/0004", dec_valid, dec_pc); end
      @(negedge clk);
      redirect = 1'b0; dec_ready = 1'b0;
      #2;
      n_chk++;
      if ({dec_valid, imem_req, imem_addr} !== {2'b01, 16'h0100}) begin n_fail++; $display("FAIL pp_flush: valid/req/addr got %b/%b/%h required 0/1/0100", dec_valid, imem_req, imem_addr); end
      n_chk++;
      if (n_issued - i0 != 3 || sb.size() != 0) begin n_fail++; $display("FAIL pp_issued: got %0d left %0d required 3 left 0", n_issued - i0, sb.size()); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_halt();
      test_redirect_drop();
      test_wrap();
      test_pop_push_redirect();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
